// File: rtl/desnorm_pkg.sv
// Shared types and IEEE-754 single-precision constants for the
// multi-channel fixed-to-float converter.
package desnorm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        PACK
    } state_t;

    localparam int          BIAS    = 127;
    localparam int          EXP_MAX = 255;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam int          MANT_W  = 23;

    typedef logic signed [11:0] exp_t;

endpackage

// File: rtl/desnorm_fixed_to_float_mc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the channel after the
// last one granted; the pointer moves only when a grant is taken.
module rr_arbiter #(
    parameter int CH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] req,
    input  logic          en,
    output logic [CH-1:0] gnt
);

    localparam int PW = (CH > 1) ? $clog2(CH) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;
    logic          found;

    always_comb begin
        logic [PW-1:0] idx;
        gnt     = '0;
        gnt_idx = ptr;
        found   = 1'b0;
        for (int unsigned i = 0; i < CH; i++) begin
            idx = PW'((int'(ptr) + 1 + int'(i)) % CH);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
    end

    // Reset pointer at the last channel so channel 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= PW'(CH - 1);
        end else if (en && found) begin
            ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/desnorm_fixed_to_float_mc.sv
// Multi-channel signed fixed-point to IEEE-754 single converter with a
// per-channel power-of-two scale, sharing one iterative normaliser.
module desnorm_fixed_to_float_mc
    import desnorm_pkg::*;
#(
    parameter int              CH        = 2,
    parameter int              W         = 32,
    parameter int              FRAC      = 16,
    parameter logic [CH*8-1:0] SCALE_EXP = {CH{8'sd0}}
) (
    input  logic            CLK,
    input  logic            RST_FF,
    input  logic [CH-1:0]   Begin_FSM_FF,
    input  logic [CH*W-1:0] F,
    output logic [CH-1:0]   ACK_FF,
    output logic [CH*32-1:0] RESULT,
    output logic [CH-1:0]   O_F,
    output logic [CH-1:0]   U_F,
    output logic            BUSY
);

    localparam int PW = (CH > 1) ? $clog2(CH) : 1;

    state_t          state, state_n;
    logic [CH-1:0]   pending, pending_n, accept, in_service, gnt;
    logic [PW-1:0]   gnt_idx, cur_idx;
    logic [W-1:0]    opnd [CH];
    logic [W-1:0]    g_op;
    logic [W-1:0]    mag;
    logic            sign;
    logic            is_zero;
    logic [6:0]      lz;
    logic [31:0]     res_q [CH];

    logic signed [7:0]   scl;
    exp_t                exp_e, exp_b;
    logic [MANT_W-1:0]   mant;
    logic [31:0]         pk_res;
    logic                pk_of, pk_uf;

    rr_arbiter #(.CH(CH)) u_arb (
        .clk (CLK),
        .rst (RST_FF),
        .req (pending),
        .en  (state == IDLE),
        .gnt (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (gnt[i]) gnt_idx = PW'(i);
        end
    end

    assign g_op = opnd[gnt_idx];

    always_comb begin
        in_service = '0;
        if (state != IDLE) in_service[cur_idx] = 1'b1;
    end

    assign accept    = Begin_FSM_FF & ~pending & ~in_service;
    assign pending_n = (pending & ~((state == IDLE) ? gnt : '0)) | accept;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (|pending) state_n = NORM;
            NORM:    if ((mag == '0) || mag[W-1]) state_n = PACK;
            PACK:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST_FF) state <= IDLE;
        else        state <= state_n;
    end

    // Mantissa from the bits below the leading one; short operands zero-pad.
    generate
        if (W >= MANT_W + 1) begin : g_mant_wide
            assign mant = mag[W-2 -: MANT_W];
        end else begin : g_mant_narrow
            assign mant = {mag[W-2:0], {(MANT_W - W + 1){1'b0}}};
        end
    endgenerate

    always_comb begin
        scl    = SCALE_EXP[int'(cur_idx)*8 +: 8];
        exp_e  = exp_t'(W - 1) - exp_t'({5'b0, lz}) - exp_t'(FRAC) + exp_t'(scl);
        exp_b  = exp_e + exp_t'(BIAS);
        pk_res = '0;
        pk_of  = 1'b0;
        pk_uf  = 1'b0;
        if (is_zero) begin
            pk_res = '0;
        end else if (exp_b >= exp_t'(EXP_MAX)) begin
            pk_res = {sign, 31'b0} | POS_INF;
            pk_of  = 1'b1;
        end else if (exp_b <= exp_t'(0)) begin
            pk_res = {sign, 31'b0};
            pk_uf  = 1'b1;
        end else begin
            pk_res = {sign, exp_b[7:0], mant};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_FF) begin
            pending <= '0;
            mag     <= '0;
            sign    <= 1'b0;
            is_zero <= 1'b0;
            lz      <= '0;
            cur_idx <= '0;
            ACK_FF  <= '0;
            O_F     <= '0;
            U_F     <= '0;
            BUSY    <= 1'b0;
            for (int unsigned c = 0; c < CH; c++) begin
                opnd[c]  <= '0;
                res_q[c] <= '0;
            end
        end else begin
            ACK_FF  <= '0;
            pending <= pending_n;
            BUSY    <= (|pending_n) || (state_n != IDLE);
            for (int unsigned c = 0; c < CH; c++) begin
                if (accept[c]) opnd[c] <= F[c*W +: W];
            end
            case (state)
                IDLE: begin
                    if (|pending) begin
                        cur_idx <= gnt_idx;
                        sign    <= g_op[W-1];
                        mag     <= g_op[W-1] ? (-g_op) : g_op;
                        lz      <= '0;
                        is_zero <= 1'b0;
                    end
                end
                NORM: begin
                    if (mag == '0) begin
                        is_zero <= 1'b1;
                    end else if (!mag[W-1]) begin
                        mag <= mag << 1;
                        lz  <= lz + 7'd1;
                    end
                end
                PACK: begin
                    res_q[cur_idx]  <= pk_res;
                    O_F[cur_idx]    <= pk_of;
                    U_F[cur_idx]    <= pk_uf;
                    ACK_FF[cur_idx] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < CH; c++) begin
            RESULT[c*32 +: 32] = res_q[c];
        end
    end

endmodule
